ifm_chunk_buf_ctrl: RTL

- Synthesizable scheduler for the multi-buffered IFM chunk store feeding the stacking inner loop.
- Sequences the IFM loader, which fills one row-chunk per buffer in round-robin order, and produces the per-buffer ready vector the inner loop polls.
- Recycles a buffer when the inner loop signals that it has finished the row.
- Tracks rows fetched and consumed per layer and pulses layer completion.

---
 rtl/ifm_chunk_buf_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ifm_chunk_buf_ctrl.sv
// IFM chunk buffer scheduler: fills row-chunks into NUM_BUF buffers round-robin,
// exposes per-buffer ready bits to the inner loop and recycles buffers on finish.
module ifm_chunk_buf_ctrl #(
    parameter int unsigned NUM_BUF     = 2,
    parameter int unsigned CHUNK_WORDS = 64,
    parameter int unsigned IFM_ROWS    = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           layer_start_i,
    output logic                           ld_req_o,
    output logic [$clog2(IFM_ROWS)-1:0]    ld_row_idx_o,
    input  logic                           ld_valid_i,
    output logic                           ld_ready_o,
    output logic                           buf_wr_en_o,
    output logic [$clog2(NUM_BUF)-1:0]     buf_wr_sel_o,
    output logic [$clog2(CHUNK_WORDS)-1:0] buf_wr_addr_o,
    output logic [NUM_BUF-1:0]             chunk_rdy_o,
    input  logic                           inner_loop_finish_i,
    output logic [$clog2(NUM_BUF)-1:0]     chunk_rd_sel_o,
    output logic                           layer_done_o,
    output logic                           busy_o,
    output logic                           proto_err_o
);

    localparam int unsigned SelW  = $clog2(NUM_BUF);
    localparam int unsigned AddrW = $clog2(CHUNK_WORDS);
    localparam int unsigned RowW  = $clog2(IFM_ROWS);
    localparam int unsigned CntW  = $clog2(IFM_ROWS + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {BufEmpty, BufFilling, BufFull} buf_st_e;

    state_e            r_state, w_state_nxt;
    buf_st_e           r_buf_st     [NUM_BUF];
    buf_st_e           w_buf_st_nxt [NUM_BUF];
    logic [SelW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [SelW-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [CntW-1:0]   r_fill_rows, w_fill_rows_nxt;
    logic [CntW-1:0]   r_cons_rows, w_cons_rows_nxt;
    logic [AddrW-1:0]  r_word_cnt, w_word_cnt_nxt;
    logic              r_proto_err, w_proto_err_nxt;

    logic w_run;
    logic w_any_filling;
    logic w_fill_start;
    logic w_ld_ready;
    logic w_accept;
    logic w_last_word;
    logic w_release;
    logic w_bad_finish;
    logic w_layer_go;

    function automatic logic [SelW-1:0] ptr_inc(input logic [SelW-1:0] p);
        return (p == SelW'(NUM_BUF - 1)) ? '0 : p + 1'b1;
    endfunction

    // Only one buffer may be mid-fill at a time; detect any in progress.
    always_comb begin
        w_any_filling = 1'b0;
        for (int unsigned i = 0; i < NUM_BUF; i++) begin
            if (r_buf_st[i] == BufFilling) begin
                w_any_filling = 1'b1;
            end
        end
    end

    // Event decode: fill start, word accept, chunk end, release and misuse of finish.
    always_comb begin
        w_run        = (r_state == StRun);
        w_fill_start = w_run && (r_buf_st[r_wr_ptr] == BufEmpty) && !w_any_filling &&
                       (r_fill_rows < CntW'(IFM_ROWS));
        // The request cycle already accepts the first word.
        w_ld_ready   = w_run && ((r_buf_st[r_wr_ptr] == BufFilling) || w_fill_start);
        w_accept     = ld_valid_i && w_ld_ready;
        w_last_word  = w_accept && (r_word_cnt == AddrW'(CHUNK_WORDS - 1));
        w_release    = inner_loop_finish_i && w_run && (r_buf_st[r_rd_ptr] == BufFull);
        w_bad_finish = inner_loop_finish_i && !w_release;
        w_layer_go   = (r_state == StIdle) && layer_start_i;
    end

    // Next-state for the layer FSM, buffer states, pointers and counters.
    always_comb begin
        w_state_nxt     = r_state;
        w_buf_st_nxt    = r_buf_st;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_fill_rows_nxt = r_fill_rows;
        w_cons_rows_nxt = r_cons_rows;
        w_word_cnt_nxt  = r_word_cnt;
        w_proto_err_nxt = r_proto_err;

        unique case (r_state)
            StIdle: begin
                if (layer_start_i) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                // The final release moves straight to DONE so the pulse follows that finish.
                if (w_release && (r_cons_rows == CntW'(IFM_ROWS - 1))) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        if (w_fill_start) begin
            w_buf_st_nxt[r_wr_ptr] = BufFilling;
        end

        if (w_accept) begin
            if (w_last_word) begin
                w_buf_st_nxt[r_wr_ptr] = BufFull;
                w_wr_ptr_nxt           = ptr_inc(r_wr_ptr);
                w_fill_rows_nxt        = r_fill_rows + 1'b1;
                w_word_cnt_nxt         = '0;
            end else begin
                w_word_cnt_nxt = r_word_cnt + 1'b1;
            end
        end

        if (w_release) begin
            w_buf_st_nxt[r_rd_ptr] = BufEmpty;
            w_rd_ptr_nxt           = ptr_inc(r_rd_ptr);
            w_cons_rows_nxt        = r_cons_rows + 1'b1;
        end

        if (w_bad_finish) begin
            w_proto_err_nxt = 1'b1;
        end

        if (w_layer_go) begin
            for (int unsigned i = 0; i < NUM_BUF; i++) begin
                w_buf_st_nxt[i] = BufEmpty;
            end
            w_wr_ptr_nxt    = '0;
            w_rd_ptr_nxt    = '0;
            w_fill_rows_nxt = '0;
            w_cons_rows_nxt = '0;
            w_word_cnt_nxt  = '0;
            w_proto_err_nxt = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            for (int unsigned i = 0; i < NUM_BUF; i++) begin
                r_buf_st[i] <= BufEmpty;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill_rows <= '0;
            r_cons_rows <= '0;
            r_word_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf_st    <= w_buf_st_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_fill_rows <= w_fill_rows_nxt;
            r_cons_rows <= w_cons_rows_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    // Ready vector: one bit per FULL buffer.
    always_comb begin
        chunk_rdy_o = '0;
        for (int unsigned i = 0; i < NUM_BUF; i++) begin
            chunk_rdy_o[i] = (r_buf_st[i] == BufFull);
        end
    end

    assign ld_req_o       = w_fill_start;
    assign ld_row_idx_o   = r_fill_rows[RowW-1:0];
    assign ld_ready_o     = w_ld_ready;
    assign buf_wr_en_o    = w_accept;
    assign buf_wr_sel_o   = r_wr_ptr;
    assign buf_wr_addr_o  = r_word_cnt;
    assign chunk_rd_sel_o = r_rd_ptr;
    assign layer_done_o   = (r_state == StDone);
    assign busy_o         = (r_state != StIdle);
    assign proto_err_o    = r_proto_err;

endmodule
